// File: rtl/native_mem_pkg.sv
// Shared types and constants for the native memory slave: FSM states,
// IO register map, error pattern and jitter LFSR definition.
package native_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [7:0] OFS_CONSOLE    = 8'h00;
  localparam logic [7:0] OFS_CYCLES     = 8'h04;
  localparam logic [7:0] OFS_DONE       = 8'h08;
  localparam logic [7:0] OFS_IFETCH_CNT = 8'h0C;
  localparam logic [7:0] OFS_DATA_CNT   = 8'h10;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  // Right-shifting Fibonacci form: taps 16/14/13/11 land on bits 0/2/3/5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int LATENCY_MAX = 15;

endpackage

// File: rtl/native_mem_lfsr16.sv
// 16-bit Fibonacci LFSR used to draw per-access wait-state jitter.
module native_mem_lfsr16
  import native_mem_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        step,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      value <= LFSR_SEED;
    end else if (step) begin
      value <= {^(value & LFSR_TAPS), value[15:1]};
    end
  end

endmodule

// File: rtl/native_mem_slave.sv
// picorv32 native-interface memory slave: RAM with byte strobes, wait-state
// generator and a small IO window (console, cycle/access counters, done flag).
module native_mem_slave
  import native_mem_pkg::*;
#(
  parameter int          MEM_WORDS    = 256,
  parameter int          LATENCY      = 0,
  parameter bit          STALL_RANDOM = 1'b0,
  parameter logic [31:0] IO_BASE      = 32'h1000_0000,
  parameter string       INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        con_valid,
  output logic [7:0]  con_data,
  output logic        done,
  output logic [31:0] done_code
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam int          LAT       = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

  state_t      state, state_next;
  logic [4:0]  wait_cnt, wait_next, load_cnt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        instr_q;
  logic [15:0] lfsr;
  logic        accept, do_access;
  logic [31:0] cycles, ifetch_cnt, data_cnt;
  logic [31:0] ram [MEM_WORDS];

  logic [31:0] acc_addr, acc_wdata, rd_data, io_rdata;
  logic [3:0]  acc_wstrb;
  logic        acc_instr, is_ram, is_io, io_ok, io_hit, is_err, con_wr, done_wr;
  logic [7:0]  ofs;
  logic [AW-1:0] ram_idx;
  logic        unused_bits;

  native_mem_lfsr16 u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .step   (accept),
    .value  (lfsr)
  );

  assign load_cnt = 5'(LAT) + (STALL_RANDOM ? {3'b000, lfsr[1:0]} : 5'd0);

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    accept     = 1'b0;
    do_access  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_valid) begin
          accept    = 1'b1;
          wait_next = load_cnt;
          if (load_cnt == 5'd0) begin
            state_next = ST_RESP;
            do_access  = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        wait_next = wait_cnt - 5'd1;
        if (wait_cnt == 5'd1) begin
          state_next = ST_RESP;
          do_access  = 1'b1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // A zero-wait access completes on the accepting edge, before the latches load.
  always_comb begin
    if (state == ST_IDLE) begin
      acc_addr  = mem_addr;
      acc_wdata = mem_wdata;
      acc_wstrb = mem_wstrb;
      acc_instr = mem_instr;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wstrb = wstrb_q;
      acc_instr = instr_q;
    end
  end

  assign is_ram  = acc_addr < RAM_BYTES;
  assign is_io   = acc_addr[31:8] == IO_BASE[31:8];
  assign ofs     = {acc_addr[7:2], 2'b00};
  assign ram_idx = acc_addr[AW+1:2];

  always_comb begin
    io_ok    = 1'b1;
    io_rdata = 32'd0;
    case (ofs)
      OFS_CONSOLE:    io_rdata = 32'd0;
      OFS_CYCLES:     io_rdata = cycles;
      OFS_DONE:       io_rdata = {31'd0, done};
      OFS_IFETCH_CNT: io_rdata = ifetch_cnt;
      OFS_DATA_CNT:   io_rdata = data_cnt;
      default:        io_ok = 1'b0;
    endcase
  end

  assign io_hit  = !is_ram && is_io && io_ok;
  assign is_err  = !is_ram && !io_hit;
  assign rd_data = is_ram ? ram[ram_idx] : (io_hit ? io_rdata : ERR_DATA);
  assign con_wr  = do_access && io_hit && (ofs == OFS_CONSOLE) && acc_wstrb[0];
  assign done_wr = do_access && io_hit && (ofs == OFS_DONE) && (|acc_wstrb);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      instr_q    <= 1'b0;
      mem_ready  <= 1'b0;
      bus_err    <= 1'b0;
      con_valid  <= 1'b0;
      con_data   <= '0;
      done       <= 1'b0;
      done_code  <= '0;
      mem_rdata  <= '0;
      cycles     <= '0;
      ifetch_cnt <= '0;
      data_cnt   <= '0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_next;
      cycles    <= cycles + 32'd1;
      mem_ready <= do_access;
      bus_err   <= do_access && is_err;
      con_valid <= con_wr;
      if (accept) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
        instr_q <= mem_instr;
      end
      if (do_access) begin
        mem_rdata <= rd_data;
        if (acc_instr) ifetch_cnt <= ifetch_cnt + 32'd1;
        else           data_cnt   <= data_cnt + 32'd1;
      end
      if (con_wr) con_data <= acc_wdata[7:0];
      if (done_wr && !done) begin
        done      <= 1'b1;
        done_code <= acc_wdata;
      end
    end
  end

  // Reset gates the write so an access dropped by reset leaves RAM untouched.
  always_ff @(posedge clk) begin
    if (resetn && do_access && is_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) ram[ram_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign unused_bits = ^{acc_addr[1:0], lfsr[15:2]};

endmodule

// File: tb/tb_native_mem_slave.sv
// Randomized scoreboard bench for native_mem_slave against a behavioural model.
module tb_native_mem_slave;

  localparam logic [31:0] IO = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready, bus_err, con_valid, done;
  logic [31:0] mem_rdata, done_code;
  logic [7:0]  con_data;

  native_mem_slave #(
    .MEM_WORDS(256), .LATENCY(0), .STALL_RANDOM(1'b1), .IO_BASE(IO), .INIT_FILE("")
  ) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err),
    .con_valid(con_valid), .con_data(con_data), .done(done), .done_code(done_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          con;
    logic [7:0]  cdata;
    int          lat;
    logic [31:0] accept_cyc;
    bit          is_cyc;
    bit          done;
    logic [31:0] code;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0, n_err = 0;

  // reference model state
  logic [31:0] m_ram [int];
  logic [31:0] m_cyc = 0, m_if = 0, m_data = 0, m_code = 0;
  bit          m_done = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  always @(posedge clk) begin
    if (!resetn) m_cyc = 0;
    else m_cyc = m_cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input bit ins);
    exp_t e;
    int   w;
    logic [31:0] old;
    e = '{rdata: 32'h0, err: 0, con: 0, cdata: 8'h0, lat: int'(m_lfsr[1:0]),
          accept_cyc: 0, is_cyc: 0, done: 0, code: 0};
    m_lfsr = lfsr_next(m_lfsr);
    if (a < 32'd1024) begin
      w   = int'(a[9:2]);
      old = m_ram.exists(w) ? m_ram[w] : 32'h0;
      e.rdata = old;
      for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = d[8*b +: 8];
      if (s != 0) m_ram[w] = old;
    end else if (a[31:8] == IO[31:8]) begin
      case (a[7:0] & 8'hFC)
        8'h00: begin e.con = s[0]; e.cdata = d[7:0]; end
        8'h04: e.is_cyc = 1;
        8'h08: begin
          e.rdata = {31'b0, m_done};
          if (s != 0 && !m_done) begin m_done = 1; m_code = d; end
        end
        8'h0C: e.rdata = m_if;
        8'h10: e.rdata = m_data;
        default: begin e.err = 1; e.rdata = 32'hDEAD_BEEF; end
      endcase
    end else begin
      e.err = 1;
      e.rdata = 32'hDEAD_BEEF;
    end
    if (ins) m_if = m_if + 1;
    else m_data = m_data + 1;
    e.done = m_done;
    e.code = m_code;
    return e;
  endfunction

  task automatic access(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit ins);
    exp_t e;
    int   n;
    @(negedge clk);
    e = model(a, d, s, ins);
    e.accept_cyc = m_cyc;
    q.push_back(e);
    mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ready && n < 40);
    chk("ready_timeout", {31'b0, mem_ready}, 32'd1);
    mem_valid = 0; mem_wstrb = 0; mem_instr = 0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (mem_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_ready", {31'b0, mem_ready}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("rdata", mem_rdata, e.is_cyc ? m_cyc - 1 : e.rdata);
        chk("bus_err", {31'b0, bus_err}, {31'b0, e.err});
        chk("con_valid", {31'b0, con_valid}, {31'b0, e.con});
        if (e.con) chk("con_data", {24'b0, con_data}, {24'b0, e.cdata});
        chk("latency", (m_cyc - 1) - e.accept_cyc, 32'(e.lat));
        chk("done", {31'b0, done}, {31'b0, e.done});
        chk("done_code", done_code, e.code);
      end
    end else if (bus_err || con_valid) begin
      chk("strobe_without_ready", {30'b0, bus_err, con_valid}, 32'd0);
    end
  end

  initial begin
    int   k, w;
    logic [31:0] a;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, mem_ready}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    resetn = 1;
    @(negedge clk);
    chk("rst_done_code", done_code, 32'd0);
    chk("rst_con_data", {24'b0, con_data}, 32'd0);

    // preload RAM through the bus
    access(32'h0, 32'h3fc00093, 4'hF, 0);
    for (int i = 1; i < 16; i++) access(32'(i * 4), $urandom, 4'hF, 0);
    access(32'h3FC, 32'hAABBCCDD, 4'hF, 0);

    // directed cases
    access(32'h0, 32'h0, 4'h0, 1);
    access(IO + 32'h0C, 32'h0, 4'h0, 0);
    access(32'h3FC, 32'h11223344, 4'b0101, 0);
    access(32'h3FC, 32'h0, 4'h0, 0);
    chk("strobe_merge_model", m_ram[255], 32'hAA22CC44);
    access(IO + 32'h0, 32'h00000041, 4'h1, 0);
    access(IO + 32'h0, 32'h0, 4'h0, 0);
    access(32'h400, 32'h0, 4'h0, 0);
    access(32'h400, 32'h12345678, 4'hF, 0);
    access(32'h0, 32'h0, 4'h0, 0);
    access(IO + 32'h14, 32'h0, 4'h0, 0);
    access(IO + 32'hFC, 32'h5, 4'hF, 0);
    access(IO + 32'h04, 32'hFFFF, 4'hF, 0);
    access(IO + 32'h04, 32'h0, 4'h0, 0);
    access(IO + 32'h08, 32'h1, 4'hF, 0);
    access(IO + 32'h08, 32'h2, 4'hF, 0);
    access(IO + 32'h08, 32'h0, 4'h0, 0);

    // randomized mix
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      w = $urandom_range(0, 16);
      if (w == 16) w = 255;
      case (k)
        0, 1, 2: access(32'(w * 4), 32'h0, 4'h0, 1'($urandom_range(0, 1)));
        3, 4:    access(32'(w * 4) | 32'($urandom_range(0, 3)), $urandom,
                        4'($urandom_range(0, 15)), 0);
        5, 6: begin
          a = IO + 32'(4 * $urandom_range(0, 5));
          access(a, $urandom, 4'($urandom_range(0, 1) * $urandom_range(0, 15)), 0);
        end
        7:       access(IO + 32'h0, $urandom, 4'($urandom_range(0, 15)), 0);
        8:       access(32'h400 + 32'(4 * $urandom_range(0, 255)), $urandom,
                        4'($urandom_range(0, 15)), 0);
        default: access(32'h2000_0000 + 32'(4 * $urandom_range(0, 63)), 32'h0, 4'h0, 0);
      endcase
    end

    // reset during the 2nd wait cycle of a write
    k = 0;
    while (m_lfsr[1:0] < 2'd2 && k < 32) begin
      access(32'h0, 32'h0, 4'h0, 0);
      k++;
    end
    a = m_ram[5];
    @(negedge clk);
    mem_valid = 1; mem_addr = 32'h14; mem_wdata = ~a; mem_wstrb = 4'hF; mem_instr = 0;
    @(negedge clk);
    chk("wait_no_ready", {31'b0, mem_ready}, 32'd0);
    @(negedge clk);
    resetn = 0; mem_valid = 0; mem_wstrb = 0;
    @(negedge clk);
    chk("rst_drop_ready", {31'b0, mem_ready}, 32'd0);
    resetn = 1;
    m_lfsr = 16'hACE1; m_if = 0; m_data = 0; m_done = 0; m_code = 0;
    @(negedge clk);
    chk("post_rst_done", {31'b0, done}, 32'd0);
    chk("post_rst_done_code", done_code, 32'd0);
    chk("post_rst_con_data", {24'b0, con_data}, 32'd0);
    access(IO + 32'h10, 32'h0, 4'h0, 0);
    access(IO + 32'h0C, 32'h0, 4'h0, 0);
    access(IO + 32'h04, 32'h0, 4'h0, 0);
    access(32'h14, 32'h0, 4'h0, 0);
    chk("rst_word_model", m_ram[5], a);
    access(32'h0, 32'h0, 4'h0, 1);
    access(IO + 32'h0C, 32'h0, 4'h0, 0);

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_done", {31'b0, done}, {31'b0, m_done});
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
